gate_truth_table_scanner: RTL and testbench
===========================================

Name: gate_truth_table_scanner

Overview:
- Stimulus/response end of the two-input gate interface: drives the gate's two inputs and reads back its single result.
- On `start`, it steps the inputs through all four combinations {a,b} = 00, 01, 10, 11.
- Each combination is held for a programmable settle time, then the gate result is sampled into a 4-bit truth table.
- The captured table is compared against an expected table. Used on the lab board to self-check any two-input gate block wired to drive_a/drive_b/gate_result.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each input combination is held before sampling. Legal values are 1 and above; 0 is treated as 1.
- EXPECTED, 4'b1000, expected truth table. Bit i is the result for combination i = {a,b}. The default is AND.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin scan; level sampled on the rising edge
- gate_result  input  1  output of the gate under test
- drive_a  output  1  gate input a (MSB of the combination index)
- drive_b  output  1  gate input b (LSB of the combination index)
- busy  output  1  high while a scan is in progress
- done  output  1  high once a scan completes; held until the next accepted start
- pass  output  1  truth_table == EXPECTED; valid while done = 1
- truth_table  output  4  captured results, bit i = combination i
- mismatch_mask  output  4  truth_table XOR EXPECTED; valid while done = 1

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, idx = 0, and settle counter = 0. All outputs go to 0 immediately, including during a scan. Scanning resumes only on a new start after rst_n is released.
- FSM states:
  - IDLE:
    - start = 1 → SCAN at the edge.
    - At that edge: idx = 0; drive_a/drive_b = 00; counter = 0; truth_table, done, pass and mismatch_mask cleared; busy = 1.
  - SCAN:
    - drive_a = idx[1], drive_b = idx[0].
    - The counter increments each cycle.
    - At the edge where counter == SETTLE_CYCLES-1: truth_table[idx] <= gate_result, and the counter returns to 0.
      - If idx < 3: idx increments, and the drives update at that same edge.
      - If idx == 3: → DONE.
  - DONE:
    - Entered at the edge that captures bit 3. At that same edge: done = 1, busy = 0, drives = 00.
    - pass and mismatch_mask are registered at that edge from the final table, including bit 3.
    - start = 1 → restart exactly as from IDLE.
- Timing: with start sampled at edge t0, combination i is driven during edges t0+i·S .. t0+(i+1)·S and sampled at edge t0+(i+1)·S, where S = SETTLE_CYCLES. done rises at edge t0+4·S.
- start while busy = 1 is ignored; there is no abort and no restart.
- start held high continuously gives back-to-back scans: one cycle in DONE with done = 1, then a restart.
- idx is 2 bits. The counter width is clog2(SETTLE_CYCLES+1). Neither wraps beyond its terminal value.
- gate_result is treated as stable at the sample edge. Without the optional synchronizer it is not synchronized.

Optional Feature:
- Macro: RESULT_SYNC_EN.
- Defined:
  - gate_result passes through a 2-flop synchronizer (reset to 0) before sampling.
  - The per-combination hold becomes SETTLE_CYCLES+2 cycles; the sample uses the synchronized value at the terminal count.
  - done rises at t0+4·(S+2).
- Undefined: gate_result is sampled directly, with timing as in Behaviour.

Test Plan:
- AND model (result = a&b), S = 4, 1-cycle start pulse → drives 00/01/10/11 for 4 cycles each; done at t0+16; truth_table = 1000; pass = 1; mismatch_mask = 0000.
- OR model, S = 4 → truth_table = 1110, pass = 0, mismatch_mask = 0110; busy low and done high from t0+16.
- Stuck-at-0 result, S = 1 → done at t0+4; truth_table = 0000; mismatch_mask = 1000.
- Extra start pulses at t0+3 and t0+9 (AND model, S = 4) → ignored; done still at t0+16. start held high → a second scan starts at t0+17, with done low from t0+17 to t0+32.
- rst_n low at t0+6 mid-scan → all outputs 0 within the same cycle; a new start after release scans from 00 and gives the full correct result.
- RESULT_SYNC_EN defined, AND model, S = 2 → each combination held 4 cycles; done at t0+16; truth_table = 1000; pass = 1.

Source files
------------

// File: rtl/gate_truth_table_scanner_if.sv
// gate_truth_table_scanner_if: start/result/drive/status bundle between a controller and the scanner.
interface gate_truth_table_scanner_if;
    logic       start;
    logic       gate_result;
    logic       drive_a;
    logic       drive_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] truth_table;
    logic [3:0] mismatch_mask;
    modport master (
        output start, gate_result,
        input  drive_a, drive_b, busy, done, pass, truth_table, mismatch_mask
    );
    modport slave (
        input  start, gate_result,
        output drive_a, drive_b, busy, done, pass, truth_table, mismatch_mask
    );
endinterface

// File: rtl/gate_truth_table_scanner.sv
// gate_truth_table_scanner: steps a two-input gate through {a,b}=00..11, captures its truth table and checks it.
// Optional RESULT_SYNC_EN: 2-flop synchronizer on gate_result, each hold extended by 2 cycles.
module gate_truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input logic clk,
    input logic rst_n,
    gate_truth_table_scanner_if.slave bus
);
    localparam int unsigned SETTLE = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
`ifdef RESULT_SYNC_EN
    localparam int unsigned HOLD = SETTLE + 2;
`else
    localparam int unsigned HOLD = SETTLE;
`endif
    localparam int unsigned CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, next_state;
    logic [1:0] idx;
    logic [CW-1:0] cnt;
    logic [3:0] table_q, table_cap, mask_q;
    logic pass_q, sample, last, accept;

`ifdef RESULT_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else sync <= {sync[0], bus.gate_result};
    assign sample = sync[1];
`else
    assign sample = bus.gate_result;
`endif

    assign last   = (state == SCAN) && (cnt == LAST);
    assign accept = (state != SCAN) && bus.start;

    // Table as it will look after this edge's capture, so pass/mask include bit 3.
    always_comb begin
        table_cap      = table_q;
        table_cap[idx] = sample;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = (state == SCAN) ? ((last && idx == 2'd3) ? DONE : SCAN)
                                     : (bus.start ? SCAN : state);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx     <= '0;
            cnt     <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
        end else if (accept) begin
            idx     <= '0;
            cnt     <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
        end else if (state == SCAN) begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
                table_q <= table_cap;
                idx     <= (idx == 2'd3) ? idx : idx + 2'd1;
                if (idx == 2'd3) begin
                    pass_q <= (table_cap == EXPECTED);
                    mask_q <= table_cap ^ EXPECTED;
                end
            end
        end

    always_comb begin
        bus.drive_a       = (state == SCAN) && idx[1];
        bus.drive_b       = (state == SCAN) && idx[0];
        bus.busy          = (state == SCAN);
        bus.done          = (state == DONE);
        bus.pass          = pass_q;
        bus.truth_table   = table_q;
        bus.mismatch_mask = mask_q;
    end
endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// tb_gate_truth_table_scanner: randomized gate tables against a cycle-timeline model of the scanner.
module tb_gate_truth_table_scanner;
`ifdef RESULT_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int HA = 4 + EXTRA;
    localparam int HB = 1 + EXTRA;
    localparam logic [3:0] EXP = 4'b1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] tbl_a = 4'b0000;
    logic [3:0] tbl_b = 4'b0000;
    int passed = 0;
    int total = 0;

    gate_truth_table_scanner_if ia();
    gate_truth_table_scanner_if ib();

    assign ia.gate_result = tbl_a[{ia.drive_a, ia.drive_b}];
    assign ib.gate_result = tbl_b[{ib.drive_a, ib.drive_b}];

    gate_truth_table_scanner #(.SETTLE_CYCLES(4), .EXPECTED(EXP)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    gate_truth_table_scanner #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        logic [12:0] oa, ob;
        rst_n = 1'b0;
        ia.start = 1'b0;
        ib.start = 1'b0;
        repeat (2) @(negedge clk);
        oa = {ia.busy, ia.done, ia.drive_a, ia.drive_b, ia.pass, ia.truth_table, ia.mismatch_mask};
        ob = {ib.busy, ib.done, ib.drive_a, ib.drive_b, ib.pass, ib.truth_table, ib.mismatch_mask};
        if (oa !== 13'd0) $display("FAIL reset_a: got %b want 0", oa); else passed++;
        total++;
        if (ob !== 13'd0) $display("FAIL reset_b: got %b want 0", ob); else passed++;
        total++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        oa = {ia.busy, ia.done, ia.drive_a, ia.drive_b, ia.pass, ia.truth_table, ia.mismatch_mask};
        if (oa !== 13'd0) $display("FAIL idle_after_reset: got %b want 0", oa); else passed++;
        total++;
    endtask

    // Scan one table; expected timeline: after edge t0+k, combination k/h is driven until k = 4h.
    task automatic scan_check(input bit use_b, input logic [3:0] tbl, input bit extra, input string name);
        int h;
        logic [3:0] ctl, ectl;
        logic [8:0] res, eres;
        h = use_b ? HB : HA;
        if (use_b) tbl_b = tbl; else tbl_a = tbl;
        @(negedge clk);
        if (use_b) ib.start = 1'b1; else ia.start = 1'b1;
        for (int k = 0; k <= 4 * h + 1; k++) begin
            @(negedge clk);
            if (use_b) ib.start = extra && (k == 2 || k == 8);
            else ia.start = extra && (k == 2 || k == 8);
            ctl = use_b ? {ib.busy, ib.done, ib.drive_a, ib.drive_b} : {ia.busy, ia.done, ia.drive_a, ia.drive_b};
            ectl = (k < 4 * h) ? {2'b10, 2'(k / h)} : 4'b0100;
            if (ctl !== ectl) $display("FAIL %s ctl k=%0d: got %b want %b", name, k, ctl, ectl); else passed++;
            total++;
            if (k >= 4 * h) begin
                res = use_b ? {ib.truth_table, ib.pass, ib.mismatch_mask} : {ia.truth_table, ia.pass, ia.mismatch_mask};
                eres = {tbl, tbl == EXP, tbl ^ EXP};
                if (res !== eres) $display("FAIL %s result k=%0d: got %b want %b", name, k, res, eres); else passed++;
                total++;
            end
        end
    endtask

    task automatic test_known_tables();
        scan_check(1'b0, 4'b1000, 1'b0, "and");
        scan_check(1'b0, 4'b1110, 1'b0, "or");
        scan_check(1'b1, 4'b0000, 1'b0, "stuck0");
    endtask

    task automatic test_random_tables();
        for (int i = 0; i < 6; i++) scan_check(1'b0, 4'($urandom), 1'b0, "rand_a");
        for (int i = 0; i < 6; i++) scan_check(1'b1, 4'($urandom), 1'b0, "rand_b");
    endtask

    task automatic test_ignored_start();
        scan_check(1'b0, 4'b1000, 1'b1, "extra_start");
    endtask

    task automatic test_back_to_back();
        logic [3:0] ctl, ectl;
        logic [8:0] res;
        tbl_a = 4'b1000;
        @(negedge clk);
        ia.start = 1'b1;
        for (int k = 0; k <= 8 * HA + 1; k++) begin
            @(negedge clk);
            if (k == 8 * HA + 1) ia.start = 1'b0;
            if (k < 4 * HA) ectl = {2'b10, 2'(k / HA)};
            else if (k == 4 * HA || k == 8 * HA + 1) ectl = 4'b0100;
            else ectl = {2'b10, 2'((k - 4 * HA - 1) / HA)};
            ctl = {ia.busy, ia.done, ia.drive_a, ia.drive_b};
            if (ctl !== ectl) $display("FAIL back_to_back ctl k=%0d: got %b want %b", k, ctl, ectl); else passed++;
            total++;
        end
        res = {ia.truth_table, ia.pass, ia.mismatch_mask};
        if (res !== {4'b1000, 1'b1, 4'b0000}) $display("FAIL back_to_back result: got %b want 100010000", res); else passed++;
        total++;
    endtask

    task automatic test_reset_mid_scan();
        logic [12:0] oa, ob;
        tbl_a = 4'b1111;
        @(negedge clk);
        ia.start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            ia.start = 1'b0;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        oa = {ia.busy, ia.done, ia.drive_a, ia.drive_b, ia.pass, ia.truth_table, ia.mismatch_mask};
        ob = {ib.busy, ib.done, ib.drive_a, ib.drive_b, ib.pass, ib.truth_table, ib.mismatch_mask};
        if (oa !== 13'd0) $display("FAIL mid_reset_a: got %b want 0", oa); else passed++;
        total++;
        if (ob !== 13'd0) $display("FAIL mid_reset_b: got %b want 0", ob); else passed++;
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        oa = {ia.busy, ia.done, ia.drive_a, ia.drive_b, ia.pass, ia.truth_table, ia.mismatch_mask};
        if (oa !== 13'd0) $display("FAIL post_reset_idle: got %b want 0", oa); else passed++;
        total++;
        scan_check(1'b0, 4'b1000, 1'b0, "after_reset");
    endtask

    initial begin
        ia.start = 1'b0;
        ib.start = 1'b0;
        test_reset();
        test_known_tables();
        test_random_tables();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
